// File: rtl/bus_slave_port.sv
// Bit-serial bus responder with local memory: decodes read/write frames, writes memory, returns read data serially.
// Optional build macro SLAVE_PARITY_EN adds an even-parity beat to write frames and a parity bit to read replies.
module bus_slave_port #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_DEPTH    = 4096,
    parameter int READ_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic slave_select,
    input  logic s_in,
    input  logic s_in_valid,
    output logic s_ready,
    output logic s_out,
    output logic s_out_valid,
    output logic done,
    output logic err
);

`ifdef SLAVE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int WR_BEATS = DATA_WIDTH + PAR_BITS;
    localparam int RD_BITS  = DATA_WIDTH + PAR_BITS;
    localparam int CNT_W    = 16;

    localparam logic [CNT_W-1:0]      ADDR_LAST  = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]      WDATA_LAST = CNT_W'(WR_BEATS - 1);
    localparam logic [CNT_W-1:0]      RLAT_LAST  = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]      RDATA_LAST = CNT_W'(RD_BITS - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L    = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_RDATA
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    r_mode;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [WR_BEATS-1:0]     r_wdata;
    logic [RD_BITS-1:0]      r_shift;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_ok;
    logic                    r_done;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_mem [0:MEM_DEPTH-1];

    logic                    w_beat;
    logic                    w_mode_load;
    logic                    w_addr_shift;
    logic                    w_data_shift;
    logic                    w_out_shift;
    logic                    w_load;
    logic                    w_mem_we;
    logic                    w_done_next;
    logic                    w_err_next;
    logic                    w_par_ok;
    logic                    w_wr_ok;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic [RD_BITS-1:0]      w_load_val;

    assign w_beat      = slave_select & s_in_valid;
    assign w_addr_next = w_addr_shift ? {s_in, r_addr[ADDR_WIDTH-1:1]} : r_addr;
    assign w_wr_ok     = ({1'b0, r_addr} < DEPTH_L);

`ifdef SLAVE_PARITY_EN
    assign w_par_ok   = ((^r_wdata[DATA_WIDTH-1:0]) == r_wdata[WR_BEATS-1]);
    assign w_load_val = r_rd_ok ? {^r_rd_data, r_rd_data} : '0;
`else
    assign w_par_ok   = 1'b1;
    assign w_load_val = r_rd_ok ? r_rd_data : '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mode_load  = 1'b0;
        w_addr_shift = 1'b0;
        w_data_shift = 1'b0;
        w_out_shift  = 1'b0;
        w_load       = 1'b0;
        w_mem_we     = 1'b0;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_beat) begin
                    w_mode_load  = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!slave_select) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else if (s_in_valid) begin
                    w_addr_shift = 1'b1;
                    if (r_cnt == ADDR_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = r_mode ? ST_MEM_RD : ST_WDATA;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (!slave_select) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else if (s_in_valid) begin
                    w_data_shift = 1'b1;
                    if (r_cnt == WDATA_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_MEM_WR;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            ST_MEM_WR: begin
                w_state_next = ST_IDLE;
                if (slave_select) begin
                    // Out-of-range addresses still complete the frame, they just never touch memory.
                    if (w_par_ok) begin
                        w_mem_we    = w_wr_ok;
                        w_done_next = 1'b1;
                    end else begin
                        w_err_next  = 1'b1;
                    end
                end
            end
            ST_MEM_RD: begin
                if (!slave_select) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else if (r_cnt == RLAT_LAST) begin
                    w_load       = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_RDATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_RDATA: begin
                if (!slave_select) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_out_shift = 1'b1;
                    if (r_cnt == RDATA_LAST) begin
                        w_cnt_next   = '0;
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_done <= w_done_next;
            r_err  <= w_err_next;
            if (w_mode_load) begin
                r_mode <= s_in;
            end
            r_addr <= w_addr_next;
            // Beats arrive LSB first, so each new bit enters at the top and walks down.
            if (w_data_shift) begin
                r_wdata <= {s_in, r_wdata[WR_BEATS-1:1]};
            end
            if (w_load) begin
                r_shift <= w_load_val;
            end else if (w_out_shift) begin
                r_shift <= {1'b0, r_shift[RD_BITS-1:1]};
            end
        end
    end

    // Read port follows the next address so the word is ready even with a one-cycle read latency.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata[DATA_WIDTH-1:0];
        end
        r_rd_data <= r_mem[w_addr_next];
        r_rd_ok   <= ({1'b0, w_addr_next} < DEPTH_L);
    end

    assign s_ready     = (r_state == ST_IDLE);
    assign s_out_valid = (r_state == ST_RDATA);
    assign s_out       = (r_state == ST_RDATA) & r_shift[0];
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port: table of write/read frames plus hand sequences for reset, abort and timing.
// Honours SLAVE_PARITY_EN when the design is built with it.
module tb_bus_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int RL = 2;
`ifdef SLAVE_PARITY_EN
    localparam int RD_BITS = DW + 1;
`else
    localparam int RD_BITS = DW;
`endif

    logic clk;
    logic reset;
    logic slave_select;
    logic s_in;
    logic s_in_valid;
    logic s_ready;
    logic s_out;
    logic s_out_valid;
    logic done;
    logic err;

    int n_tests;
    int n_fail;
    int done_cnt;
    int err_cnt;
    int exp_done;
    int exp_err;

    bus_slave_port #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MEM_DEPTH   (4096),
        .READ_LATENCY(RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .slave_select(slave_select),
        .s_in        (s_in),
        .s_in_valid  (s_in_valid),
        .s_ready     (s_ready),
        .s_out       (s_out),
        .s_out_valid (s_out_valid),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && done) done_cnt++;
        if (reset && err)  err_cnt++;
    end

    typedef struct {
        logic        is_rd;
        logic [11:0] addr;
        logic [7:0]  data;
        int          gap;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic b, input int gap);
        slave_select = 1'b1;
        s_in_valid   = 1'b0;
        repeat (gap) step();
        s_in       = b;
        s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
        s_in       = 1'b0;
    endtask

    task automatic send_write_beats(input logic [11:0] addr, input logic [7:0] data, input int gap);
        send_beat(1'b0, gap);
        for (int i = 0; i < AW; i++) send_beat(addr[i], gap);
        for (int i = 0; i < DW; i++) send_beat(data[i], gap);
`ifdef SLAVE_PARITY_EN
        send_beat(^data, gap);
`endif
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [7:0] data, input int gap);
        send_write_beats(addr, data, gap);
        check("wr_done_early", 32'(done), 32'd0);
        check("wr_busy", 32'(s_ready), 32'd0);
        step();
        check("wr_done", 32'(done), 32'd1);
        check("wr_ready_with_done", 32'(s_ready), 32'd1);
        exp_done++;
    endtask

    task automatic do_read(input logic [11:0] addr, input logic [7:0] exp, input int gap);
        logic [RD_BITS-1:0] bits;
        bits = '0;
        send_beat(1'b1, gap);
        for (int i = 0; i < AW; i++) send_beat(addr[i], gap);
        check("rd_valid_lat", 32'(s_out_valid), 32'd0);
        for (int k = 1; k < RL; k++) begin
            step();
            check("rd_valid_lat", 32'(s_out_valid), 32'd0);
        end
        step();
        for (int i = 0; i < RD_BITS; i++) begin
            check("rd_valid_bit", 32'(s_out_valid), 32'd1);
            bits[i] = s_out;
            step();
        end
        check("rd_valid_end", 32'(s_out_valid), 32'd0);
        check("rd_done", 32'(done), 32'd1);
        check("rd_ready_with_done", 32'(s_ready), 32'd1);
        check("rd_data", 32'(bits[DW-1:0]), 32'(exp));
`ifdef SLAVE_PARITY_EN
        check("rd_parity", 32'(bits[DW]), 32'(^exp));
`endif
        $display("[TB] read addr=0x%0h data=0x%0h expected=0x%0h", addr, bits[DW-1:0], exp);
        exp_done++;
    endtask

    task automatic idle_select();
        slave_select = 1'b1;
        s_in_valid   = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        n_tests = 0; n_fail = 0; done_cnt = 0; err_cnt = 0; exp_done = 0; exp_err = 0;

        vecs[0] = '{is_rd: 1'b0, addr: 12'd1001, data: 8'h65, gap: 0};
        vecs[1] = '{is_rd: 1'b1, addr: 12'd1001, data: 8'h65, gap: 0};
        vecs[2] = '{is_rd: 1'b0, addr: 12'd5,    data: 8'hA5, gap: 3};
        vecs[3] = '{is_rd: 1'b1, addr: 12'd5,    data: 8'hA5, gap: 0};
        vecs[4] = '{is_rd: 1'b0, addr: 12'd0,    data: 8'hFF, gap: 0};
        vecs[5] = '{is_rd: 1'b0, addr: 12'd4095, data: 8'h81, gap: 1};
        vecs[6] = '{is_rd: 1'b1, addr: 12'd0,    data: 8'hFF, gap: 2};
        vecs[7] = '{is_rd: 1'b1, addr: 12'd4095, data: 8'h81, gap: 0};
        vecs[8] = '{is_rd: 1'b1, addr: 12'd1001, data: 8'h65, gap: 0};

        reset = 1'b0; slave_select = 1'b0; s_in = 1'b0; s_in_valid = 1'b0;
        repeat (3) step();
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_s_out", 32'(s_out), 32'd0);
        check("rst_s_out_valid", 32'(s_out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        step();

        // Reset asserted in the middle of an address phase acts without waiting for a clock edge.
        send_beat(1'b0, 0);
        for (int i = 0; i < 3; i++) send_beat(1'b1, 0);
        check("mid_addr_busy", 32'(s_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ready", 32'(s_ready), 32'd1);
        check("async_rst_valid", 32'(s_out_valid), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        slave_select = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("post_rst_ready", 32'(s_ready), 32'd1);
        $display("[TB] reset mid-frame s_ready=%0b", s_ready);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].is_rd) begin
                do_read(vecs[v].addr, vecs[v].data, vecs[v].gap);
            end else begin
                do_write(vecs[v].addr, vecs[v].data, vecs[v].gap);
                $display("[TB] write addr=0x%0h data=0x%0h gap=%0d done=%0b", vecs[v].addr, vecs[v].data, vecs[v].gap, done);
            end
        end
        idle_select();
        check("done_count_table", 32'(done_cnt), 32'(exp_done));

        // Deselect after six address beats of a write to address 5.
        send_beat(1'b0, 0);
        for (int i = 0; i < 6; i++) send_beat(1'(12'd5 >> i), 0);
        slave_select = 1'b0;
        step();
        check("abort_addr_ready", 32'(s_ready), 32'd1);
        idle_select();
        check("abort_addr_no_done", 32'(done_cnt), 32'(exp_done));
        do_read(12'd5, 8'hA5, 0);
        $display("[TB] abort after 6 address beats, done_cnt=%0d", done_cnt);

        // Deselect in the middle of read data.
        send_beat(1'b1, 0);
        for (int i = 0; i < AW; i++) send_beat(1'(12'd1001 >> i), 0);
        repeat (RL + 2) step();
        check("abort_rd_active", 32'(s_out_valid), 32'd1);
        slave_select = 1'b0;
        step();
        check("abort_rd_valid", 32'(s_out_valid), 32'd0);
        check("abort_rd_ready", 32'(s_ready), 32'd1);
        repeat (DW) step();
        check("abort_rd_no_done", 32'(done_cnt), 32'(exp_done));
        $display("[TB] abort during read data, s_out_valid=%0b", s_out_valid);

        // Beats without select are ignored.
        slave_select = 1'b0; s_in_valid = 1'b1; s_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("unselected_ignored", 32'(s_ready), 32'd1);
        end
        s_in_valid = 1'b0; s_in = 1'b0;
        $display("[TB] unselected beats ignored, s_ready=%0b", s_ready);

        // Reset landing in the memory-write cycle must cancel the write.
        do_write(12'd7, 8'h3C, 0);
        send_write_beats(12'd7, 8'hFF, 0);
        reset = 1'b0;
        #2;
        check("rst_memwr_done", 32'(done), 32'd0);
        slave_select = 1'b0;
        step();
        check("rst_memwr_done_edge", 32'(done), 32'd0);
        reset = 1'b1;
        step();
        do_read(12'd7, 8'h3C, 0);
        $display("[TB] reset during memory write, mem[7] kept");

`ifdef SLAVE_PARITY_EN
        // Wrong parity on a write: err instead of done, memory untouched.
        send_beat(1'b0, 0);
        for (int i = 0; i < AW; i++) send_beat(1'(12'd1001 >> i), 0);
        for (int i = 0; i < DW; i++) send_beat(1'(8'h12 >> i), 0);
        send_beat(~(^8'h12), 0);
        check("par_err_early", 32'(err), 32'd0);
        step();
        check("par_err", 32'(err), 32'd1);
        check("par_no_done", 32'(done), 32'd0);
        exp_err++;
        step();
        check("par_err_pulse", 32'(err), 32'd0);
        do_read(12'd1001, 8'h65, 0);
        $display("[TB] bad parity write rejected");
`endif

        idle_select();
        check("done_count_final", 32'(done_cnt), 32'(exp_done));
        check("err_count_final", 32'(err_cnt), 32'(exp_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
